ground_enemy_ctrl: RTL and testbench

//  Parametrised walker-enemy controller: spawns at a pseudo-random screen edge, chases
//  the player horizontally with 2-frame walk animation, takes HP hits from N shots,

---
 rtl/ground_enemy_if.sv | 40 ++++
 rtl/ground_enemy_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_ground_enemy_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ground_enemy_if.sv
// Bundles the enemy controller's game-side inputs and compositor/score/damage outputs.
interface ground_enemy_if #(
    parameter int unsigned SPR_W     = 18,
    parameter int unsigned SPR_H     = 19,
    parameter int unsigned NUM_SHOTS = 2
);
    localparam int unsigned SPR_BITS = 2 * SPR_W * SPR_H;

    logic                      run;
    logic [9:0]                player_x;
    logic [9:0]                player_y;
    logic [10*NUM_SHOTS-1:0]   shot_x;
    logic [10*NUM_SHOTS-1:0]   shot_y;
    logic [NUM_SHOTS-1:0]      shot_vld;
    logic [SPR_BITS-1:0]       spr_l1;
    logic [SPR_BITS-1:0]       spr_l2;
    logic [SPR_BITS-1:0]       spr_r1;
    logic [SPR_BITS-1:0]       spr_r2;
    logic [SPR_BITS-1:0]       sprite;
    logic [9:0]                enemy_x;
    logic [9:0]                enemy_y;
    logic                      alive;
    logic                      kill;
    logic                      player_col;
    logic [3:0]                hp_left;

    // Game/testbench side
    modport master (
        output run, player_x, player_y, shot_x, shot_y, shot_vld,
               spr_l1, spr_l2, spr_r1, spr_r2,
        input  sprite, enemy_x, enemy_y, alive, kill, player_col, hp_left
    );

    // Enemy controller side
    modport slave (
        input  run, player_x, player_y, shot_x, shot_y, shot_vld,
               spr_l1, spr_l2, spr_r1, spr_r2,
        output sprite, enemy_x, enemy_y, alive, kill, player_col, hp_left
    );
endinterface

// File: rtl/ground_enemy_ctrl.sv
// Walker enemy: spawns at a pseudo-random edge, chases the player horizontally,
// takes hits from player shots, blinks while invulnerable, dies and respawns.
module ground_enemy_ctrl #(
    parameter int unsigned SPR_W     = 18,
    parameter int unsigned SPR_H     = 19,
    parameter int unsigned PLY_W     = 31,
    parameter int unsigned PLY_H     = 30,
    parameter int unsigned SPEED     = 3,
    parameter int unsigned ANIM_DIV  = 4,
    parameter int unsigned HP        = 2,
    parameter int unsigned INVULN    = 8,
    parameter int unsigned RESPAWN   = 250,
    parameter int unsigned SPAWN_XL  = 3,
    parameter int unsigned SPAWN_XR  = 636,
    parameter int unsigned SPAWN_Y   = 380,
    parameter int unsigned X_MAX     = 639,
    parameter int unsigned NUM_SHOTS = 2
) (
    input  logic           frame_clk,
    input  logic           reset,
    ground_enemy_if.slave  bus
);
    localparam int unsigned SPR_BITS = 2 * SPR_W * SPR_H;
    localparam int unsigned DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int unsigned INV_W    = $clog2(INVULN + 1);
    localparam int unsigned RSP_W    = $clog2(RESPAWN + 1);
    localparam logic [10:0] X_LIM    = 11'(X_MAX - SPR_W + 1);
    localparam logic [10:0] SPEED11  = 11'(SPEED);

    typedef enum logic [2:0] {IDLE, SPAWN, WALK, HIT, DEAD} state_t;

    state_t              state;
    logic [DIV_W-1:0]    div;
    logic [7:0]          lfsr;
    logic [INV_W-1:0]    inv_cnt;
    logic [RSP_W-1:0]    rsp_cnt;
    logic                facing;
    logic                phase;
    logic [SPR_BITS-1:0] sprite_q;
    logic [9:0]          x_q;
    logic [9:0]          y_q;
    logic                alive_q;
    logic                kill_q;
    logic                pcol_q;
    logic [3:0]          hp_q;

    logic                step_c;
    logic                hit_c;
    logic                ovl_c;
    logic                face_n;
    logic [10:0]         ex11;
    logic [10:0]         ey11;
    logic [10:0]         px11;
    logic [10:0]         py11;
    logic [10:0]         dx;
    logic [10:0]         nx_c;
    logic [SPR_BITS-1:0] walk_spr;

    assign step_c = (div == DIV_W'(ANIM_DIV - 1));

    // Chase step toward the player, limited to SPEED and clamped to the screen.
    always_comb begin
        ex11   = {1'b0, x_q};
        ey11   = {1'b0, y_q};
        px11   = {1'b0, bus.player_x};
        py11   = {1'b0, bus.player_y};
        face_n = facing;
        dx     = 11'd0;
        nx_c   = ex11;
        if (px11 > ex11) begin
            dx     = px11 - ex11;
            nx_c   = ex11 + ((dx < SPEED11) ? dx : SPEED11);
            face_n = 1'b1;
        end else if (px11 < ex11) begin
            dx     = ex11 - px11;
            nx_c   = ex11 - ((dx < SPEED11) ? dx : SPEED11);
            face_n = 1'b0;
        end
        if (nx_c > X_LIM) begin
            nx_c = X_LIM;
        end
    end

    // Any live shot inside the enemy box counts as one hit.
    always_comb begin
        hit_c = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            logic [10:0] sx;
            logic [10:0] sy;
            sx = {1'b0, bus.shot_x[10*i +: 10]};
            sy = {1'b0, bus.shot_y[10*i +: 10]};
            if (bus.shot_vld[i] &&
                sx >= ex11 && sx <= ex11 + 11'(SPR_W - 1) &&
                sy >= ey11 && sy <= ey11 + 11'(SPR_H - 1)) begin
                hit_c = 1'b1;
            end
        end
    end

    // Enemy/player bounding-box overlap.
    assign ovl_c = (ex11 < px11 + 11'(PLY_W)) && (px11 < ex11 + 11'(SPR_W)) &&
                   (ey11 < py11 + 11'(PLY_H)) && (py11 < ey11 + 11'(SPR_H));

    // Walk frame for the facing/phase this step will leave behind.
    always_comb begin
        walk_spr = '0;
        case ({face_n, ~phase})
            2'b10:   walk_spr = bus.spr_r1;
            2'b11:   walk_spr = bus.spr_r2;
            2'b00:   walk_spr = bus.spr_l1;
            default: walk_spr = bus.spr_l2;
        endcase
    end

    // Frame divider, LFSR and enemy state machine.
    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div      <= '0;
            lfsr     <= 8'hA5;
            inv_cnt  <= '0;
            rsp_cnt  <= '0;
            facing   <= 1'b1;
            phase    <= 1'b0;
            sprite_q <= '0;
            x_q      <= 10'(SPAWN_XL);
            y_q      <= 10'(SPAWN_Y);
            alive_q  <= 1'b0;
            kill_q   <= 1'b0;
            pcol_q   <= 1'b0;
            hp_q     <= 4'(HP);
        end else begin
            lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            div    <= step_c ? '0 : div + DIV_W'(1);
            kill_q <= 1'b0;
            if (step_c) begin
                if (!bus.run) begin
                    state    <= IDLE;
                    sprite_q <= '0;
                    alive_q  <= 1'b0;
                    pcol_q   <= 1'b0;
                    inv_cnt  <= '0;
                    rsp_cnt  <= '0;
                    phase    <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            state <= SPAWN;
                        end
                        SPAWN: begin
                            facing   <= ~lfsr[0];
                            x_q      <= lfsr[0] ? 10'(SPAWN_XR) : 10'(SPAWN_XL);
                            y_q      <= 10'(SPAWN_Y);
                            hp_q     <= 4'(HP);
                            phase    <= 1'b0;
                            sprite_q <= lfsr[0] ? bus.spr_l1 : bus.spr_r1;
                            alive_q  <= 1'b1;
                            pcol_q   <= 1'b0;
                            state    <= WALK;
                        end
                        WALK: begin
                            if (hit_c && hp_q == 4'd1) begin
                                hp_q     <= 4'd0;
                                kill_q   <= 1'b1;
                                sprite_q <= '0;
                                alive_q  <= 1'b0;
                                pcol_q   <= 1'b0;
                                rsp_cnt  <= '0;
                                state    <= DEAD;
                            end else begin
                                x_q      <= nx_c[9:0];
                                facing   <= face_n;
                                phase    <= ~phase;
                                sprite_q <= walk_spr;
                                if (hit_c) begin
                                    hp_q    <= hp_q - 4'd1;
                                    inv_cnt <= '0;
                                    pcol_q  <= 1'b0;
                                    state   <= HIT;
                                end else begin
                                    pcol_q  <= ovl_c;
                                end
                            end
                        end
                        HIT: begin
                            x_q      <= nx_c[9:0];
                            facing   <= face_n;
                            phase    <= ~phase;
                            sprite_q <= inv_cnt[0] ? '0 : walk_spr;
                            pcol_q   <= 1'b0;
                            if (inv_cnt == INV_W'(INVULN - 1)) begin
                                inv_cnt <= '0;
                                state   <= WALK;
                            end else begin
                                inv_cnt <= inv_cnt + INV_W'(1);
                            end
                        end
                        DEAD: begin
                            if (rsp_cnt == RSP_W'(RESPAWN - 1)) begin
                                rsp_cnt <= '0;
                                state   <= SPAWN;
                            end else begin
                                rsp_cnt <= rsp_cnt + RSP_W'(1);
                            end
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.sprite     = sprite_q;
    assign bus.enemy_x    = x_q;
    assign bus.enemy_y    = y_q;
    assign bus.alive      = alive_q;
    assign bus.kill       = kill_q;
    assign bus.player_col = pcol_q;
    assign bus.hp_left    = hp_q;
endmodule

// File: tb/tb_ground_enemy_ctrl.sv
// Randomized bench for ground_enemy_ctrl against a frame-level behavioural model.
module tb_ground_enemy_ctrl;
    localparam int SPR_W = 18, SPR_H = 19, PLY_W = 31, PLY_H = 30;
    localparam int SPEED = 3, ANIM_DIV = 4, HP = 2, INVULN = 8, RESPAWN = 250;
    localparam int SPAWN_XL = 3, SPAWN_XR = 636, SPAWN_Y = 380, X_MAX = 639, NS = 2;
    localparam int SB = 2 * SPR_W * SPR_H;
    localparam int M_IDLE = 0, M_SPAWN = 1, M_WALK = 2, M_HIT = 3, M_DEAD = 4;

    logic frame_clk = 1'b0;
    logic reset     = 1'b1;
    always #5 frame_clk = ~frame_clk;

    ground_enemy_if #(.SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_SHOTS(NS)) bus ();

    ground_enemy_ctrl #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .PLY_W(PLY_W), .PLY_H(PLY_H), .SPEED(SPEED),
        .ANIM_DIV(ANIM_DIV), .HP(HP), .INVULN(INVULN), .RESPAWN(RESPAWN),
        .SPAWN_XL(SPAWN_XL), .SPAWN_XR(SPAWN_XR), .SPAWN_Y(SPAWN_Y),
        .X_MAX(X_MAX), .NUM_SHOTS(NS)
    ) dut (
        .frame_clk (frame_clk),
        .reset     (reset),
        .bus       (bus.slave)
    );

    int n_chk = 0, n_pass = 0, kill_seen = 0;
    logic [SB-1:0] f_r1, f_r2, f_l1, f_l2;

    // model state
    int m_mode, m_div, m_x, m_y, m_hp, m_face, m_phase, m_inv, m_resp;
    int m_spr, m_alive, m_kill, m_pcol;
    bit [7:0] m_lfsr;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic int spr_code(input logic [SB-1:0] s);
        if (s == '0) return 0;
        if (s == f_r1) return 1;
        if (s == f_r2) return 2;
        if (s == f_l1) return 3;
        if (s == f_l2) return 4;
        return 7;
    endfunction

    function automatic int frame_code(input int face, input int ph);
        return face ? (ph ? 2 : 1) : (ph ? 4 : 3);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_div = 0; m_x = SPAWN_XL; m_y = SPAWN_Y; m_hp = HP;
        m_face = 1; m_phase = 0; m_inv = 0; m_resp = 0; m_spr = 0;
        m_alive = 0; m_kill = 0; m_pcol = 0; m_lfsr = 8'hA5;
    endtask

    function automatic bit shot_hits();
        for (int i = 0; i < NS; i++) begin
            int sx, sy;
            sx = int'(bus.shot_x[10*i +: 10]);
            sy = int'(bus.shot_y[10*i +: 10]);
            if (bus.shot_vld[i] && sx >= m_x && sx < m_x + SPR_W &&
                sy >= m_y && sy < m_y + SPR_H) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int overlaps();
        int px, py;
        px = int'(bus.player_x);
        py = int'(bus.player_y);
        return (m_x < px + PLY_W && px < m_x + SPR_W &&
                m_y < py + PLY_H && py < m_y + SPR_H) ? 1 : 0;
    endfunction

    task automatic walk_move();
        int px;
        px = int'(bus.player_x);
        if (px > m_x) begin m_x = m_x + imin(SPEED, px - m_x); m_face = 1; end
        else if (px < m_x) begin m_x = m_x - imin(SPEED, m_x - px); m_face = 0; end
        if (m_x > X_MAX - SPR_W + 1) m_x = X_MAX - SPR_W + 1;
        m_phase = 1 - m_phase;
    endtask

    task automatic model_step();
        bit step;
        bit [7:0] lf_old;
        bit hit;
        step   = (m_div == ANIM_DIV - 1);
        lf_old = m_lfsr;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        m_div  = step ? 0 : m_div + 1;
        m_kill = 0;
        if (!step) return;
        if (!bus.run) begin
            m_mode = M_IDLE; m_spr = 0; m_alive = 0; m_pcol = 0;
            m_inv = 0; m_resp = 0; m_phase = 0;
            return;
        end
        case (m_mode)
            M_IDLE: m_mode = M_SPAWN;
            M_SPAWN: begin
                m_face = lf_old[0] ? 0 : 1;
                m_x = lf_old[0] ? SPAWN_XR : SPAWN_XL;
                m_y = SPAWN_Y; m_hp = HP; m_phase = 0; m_alive = 1; m_pcol = 0;
                m_spr = frame_code(m_face, 0); m_mode = M_WALK;
            end
            M_WALK: begin
                hit = shot_hits();
                if (hit && m_hp == 1) begin
                    m_hp = 0; m_mode = M_DEAD; m_kill = 1; m_spr = 0;
                    m_alive = 0; m_pcol = 0; m_resp = 0;
                end else begin
                    if (hit) begin m_hp--; m_mode = M_HIT; m_inv = 0; m_pcol = 0; end
                    else m_pcol = overlaps();
                    walk_move();
                    m_spr = frame_code(m_face, m_phase);
                end
            end
            M_HIT: begin
                walk_move();
                m_spr = (m_inv % 2 == 1) ? 0 : frame_code(m_face, m_phase);
                m_pcol = 0;
                if (m_inv == INVULN - 1) begin m_mode = M_WALK; m_inv = 0; end
                else m_inv++;
            end
            default: begin
                if (m_resp == RESPAWN - 1) begin m_mode = M_SPAWN; m_resp = 0; end
                else m_resp++;
            end
        endcase
    endtask

    task automatic compare_all();
        if (bus.kill === 1'b1) kill_seen++;
        check("sprite",     spr_code(bus.sprite), m_spr);
        check("enemy_x",    int'(bus.enemy_x), m_x);
        check("enemy_y",    int'(bus.enemy_y), m_y);
        check("alive",      int'(bus.alive), m_alive);
        check("kill",       int'(bus.kill), m_kill);
        check("player_col", int'(bus.player_col), m_pcol);
        check("hp_left",    int'(bus.hp_left), m_hp);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        if (reset) model_reset();
        else model_step();
        #1 compare_all();
    endtask

    // Shots: aim0/aim1 target the enemy body, rnd gives random live shots otherwise.
    task automatic set_shots(input bit aim0, input bit aim1, input bit rnd);
        logic [10*NS-1:0] sx, sy;
        logic [NS-1:0] v;
        sx = '0; sy = '0; v = '0;
        for (int i = 0; i < NS; i++) begin
            bit aim;
            aim = (i == 0) ? aim0 : aim1;
            if (aim) begin
                sx[10*i +: 10] = 10'(m_x + 5 + i);
                sy[10*i +: 10] = 10'(m_y + 5 + i);
                v[i] = 1'b1;
            end else if (rnd && $urandom_range(0, 9) == 0) begin
                sx[10*i +: 10] = 10'($urandom_range(0, 639));
                sy[10*i +: 10] = 10'($urandom_range(300, 479));
                v[i] = 1'b1;
            end
        end
        bus.shot_x = sx; bus.shot_y = sy; bus.shot_vld = v;
    endtask

    task automatic wait_mode(input int mode, input int budget, input string tag);
        int n;
        n = 0;
        while (m_mode != mode && n < budget) begin tick(); n++; end
        if (m_mode != mode) check({tag, "_timeout"}, m_mode, mode);
    endtask

    initial begin
        for (int i = 0; i < SB; i++) begin
            f_r1[i] = 1'($urandom_range(0, 1)); f_r2[i] = 1'($urandom_range(0, 1));
            f_l1[i] = 1'($urandom_range(0, 1)); f_l2[i] = 1'($urandom_range(0, 1));
        end
        f_r1[7:0] = 8'h11; f_r2[7:0] = 8'h22; f_l1[7:0] = 8'h33; f_l2[7:0] = 8'h44;
        bus.spr_r1 = f_r1; bus.spr_r2 = f_r2; bus.spr_l1 = f_l1; bus.spr_l2 = f_l2;
        bus.run = 1'b0; bus.player_x = 10'd100; bus.player_y = 10'd0;
        set_shots(0, 0, 0);
        model_reset();

        // reset values
        tick(); tick();
        reset = 1'b0;

        // spawn and chase to x=100
        bus.run = 1'b1;
        for (int c = 0; c < 1000; c++) tick();
        check("stop_at_100", int'(bus.enemy_x), 100);

        // single non-fatal hit, further shots during invulnerability ignored
        wait_mode(M_WALK, 40, "walk1");
        for (int c = 0; c < 40 && m_mode == M_WALK; c++) begin set_shots(1, 0, 0); tick(); end
        for (int c = 0; c < 24; c++) begin set_shots(1, 1, 0); tick(); end
        set_shots(0, 0, 0);
        check("hp_after_hit", int'(bus.hp_left), HP - 1);
        wait_mode(M_WALK, 40, "invuln_end");

        // fatal hit with both shots in the same step
        kill_seen = 0;
        for (int c = 0; c < 40 && m_mode == M_WALK; c++) begin set_shots(1, 1, 0); tick(); end
        set_shots(0, 0, 0);
        for (int c = 0; c < 40; c++) tick();
        check("kill_pulses", kill_seen, 1);
        for (int c = 0; c < 4 * RESPAWN + 20; c++) tick();
        check("respawned", int'(bus.alive), 1);

        // right and left clamps
        bus.player_x = 10'd639;
        for (int c = 0; c < 1000; c++) tick();
        check("clamp_right", int'(bus.enemy_x), X_MAX - SPR_W + 1);
        bus.player_x = 10'd0;
        for (int c = 0; c < 1000; c++) tick();
        check("clamp_left", int'(bus.enemy_x), 0);

        // player overlapping enemy
        bus.player_y = 10'd375;
        for (int c = 0; c < 12; c++) tick();
        check("collide", int'(bus.player_col), 1);

        // random play
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                bus.player_x = 10'($urandom_range(0, 639));
                bus.player_y = 10'($urandom_range(300, 420));
            end
            set_shots($urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0, 1);
            if ($urandom_range(0, 499) == 0) bus.run = 1'b0;
            else if (!bus.run && $urandom_range(0, 15) == 0) bus.run = 1'b1;
            tick();
        end
        set_shots(0, 0, 0);
        bus.run = 1'b1;

        // run=0 mid-walk
        wait_mode(M_WALK, 1200, "walk2");
        bus.run = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        check("idle_sprite", spr_code(bus.sprite), 0);
        bus.run = 1'b1;

        // reset while dead
        wait_mode(M_WALK, 40, "walk3");
        for (int c = 0; c < 200 && m_mode != M_DEAD; c++) begin
            set_shots(m_mode == M_WALK, 0, 0); tick();
        end
        set_shots(0, 0, 0);
        for (int c = 0; c < 10; c++) tick();
        #2 reset = 1'b1;
        model_reset();
        #1 compare_all();
        check("reset_dead_x", int'(bus.enemy_x), SPAWN_XL);
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 40; c++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
